axis_byte_pkt_arb: RTL and testbench
====================================

# axis_byte_pkt_arb

Packet-granular round-robin arbiter that shares the single byte-wide input of the 8-to-64 AXI4-Stream width converter among NUM_SRC byte-stream sources. Once a source is granted, it holds the grant until its packet ends on tlast. Packets longer than MAX_LEN bytes are truncated with a forced tlast, and the rest of the offending packet is drained. The block sits directly upstream of the converter, and its m_axis_* port connects to the converter's s_axis_* port.

## Interface
- NUM_SRC, 4: number of requesting byte streams, 2..16.
- MAX_LEN, 1024: maximum bytes per output packet, ≥2.
- SRC_W, $clog2(NUM_SRC): width of the source ID (derived).
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  8*NUM_SRC  source bytes; source i occupies bits [8i+7:8i].
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source end of packet.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  8  byte to the converter.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output end of packet (source tlast or forced).
- m_axis_tuser  out  SRC_W  ID of the granted source, stable for the whole packet.
- m_axis_tready  in  1  converter ready.
- trunc_err  out  NUM_SRC  sticky flag per source: that source's packet was truncated.
- trunc_clr  in  1  single-cycle pulse that clears all trunc_err bits.

## Operation
- State machine with three states: IDLE, PASS, DRAIN.
- IDLE:
  - All s_axis_tready = 0 and m_axis_tvalid = 0.
  - If any s_axis_tvalid is high, select the first valid source at or after rr_ptr, searching upward and wrapping modulo NUM_SRC.
  - Register that source as grant, clear len_cnt, and go to PASS.
- PASS (combinational mux from grant):
  - m_axis_tdata = s_axis_tdata[grant] and m_axis_tvalid = s_axis_tvalid[grant].
  - s_axis_tready[grant] = m_axis_tready; every other ready is 0.
  - m_axis_tlast = s_axis_tlast[grant] | (len_cnt == MAX_LEN-1).
  - Every transfer (m_axis_tvalid & m_axis_tready) increments len_cnt.
  - Transfer with s_axis_tlast[grant] = 1: go to IDLE and set rr_ptr = (grant+1) mod NUM_SRC. This applies even when len_cnt == MAX_LEN-1; that packet is exactly MAX_LEN bytes, so no error and no drain.
  - Transfer with len_cnt == MAX_LEN-1 and s_axis_tlast[grant] = 0: set trunc_err[grant] and go to DRAIN.
- DRAIN:
  - m_axis_tvalid = 0 and s_axis_tready[grant] = 1; incoming bytes are discarded.
  - A beat with s_axis_tvalid[grant] & s_axis_tlast[grant]: go to IDLE and advance rr_ptr as in PASS.
- m_axis_tuser = grant in all states; don't-care while m_axis_tvalid = 0.
- len_cnt is $clog2(MAX_LEN) bits wide and never wraps, because it is cleared on every grant.
- If trunc_clr and a new truncation on the same source occur in the same cycle, set wins.
- Sources that are not granted see tready = 0 and must hold their data (AXI rule).

## Timing
- Reset values (asynchronous on areset):
  - State IDLE, grant 0, rr_ptr 0, len_cnt 0, trunc_err 0.
  - Therefore m_axis_tvalid 0, m_axis_tlast 0, m_axis_tuser 0, s_axis_tready all 0.
- Reset mid-packet: outputs go inactive immediately. The partial packet is abandoned, and no tlast is generated toward the converter.
- Arbitration bubble: exactly 1 cycle in IDLE between packets. The first byte can transfer in the cycle after the request is first seen in IDLE.
- Data path is combinational, with zero-cycle latency in PASS. Paths m_axis_tready → s_axis_tready and s_axis_tvalid → m_axis_tvalid are combinational.
- Sustained throughput is 1 byte/cycle within a packet, with a 1-cycle gap per packet.
- Truncation: the forced-tlast byte is the MAX_LEN-th byte. DRAIN starts the next cycle. trunc_err rises the cycle after the forced-tlast transfer.
- DRAIN with source tlast on its first cycle: back in IDLE one cycle later.

## Test plan
- Single source: source 2 sends 01,02,03,04 with tlast on 04 and m_axis_tready = 1 → output bytes 01..04 on consecutive cycles, tuser = 2, tlast only on 04, trunc_err = 0.
- Fairness: sources 0 and 1 each continuously offer 2-byte packets (0: A0,A1; 1: B0,B1) → output order A0 A1, B0 B1, A0 A1, B0 B1 …, with a 1-cycle gap between packets and tuser alternating 0/1.
- Truncation, with MAX_LEN = 8: source 3 sends a 10-byte packet 01..0A → output 01..08 with tlast on 08. Bytes 09 and 0A are accepted but not output, trunc_err = 4'b1000, and the next packet from source 3 arrives intact. A trunc_clr pulse then clears trunc_err to 0.
- Exact length, with MAX_LEN = 8: an 8-byte packet with tlast on byte 8 → 8 bytes out with tlast on 8, no DRAIN, trunc_err stays 0.
- Backpressure: m_axis_tready toggling 1,0,1,0 during a 4-byte packet → each byte output exactly once, in order, and the source is never acknowledged while m_axis_tready = 0.
- Reset mid-packet: areset asserted after 2 of 4 bytes → m_axis_tvalid and all s_axis_tready go 0 asynchronously. After release, arbitration restarts at source 0.

Source files
------------

// File: rtl/axis_byte_pkt_arb.sv
// Packet-granular round-robin arbiter feeding one byte-wide AXI4-Stream port.
// Packets longer than MAX_LEN are cut with a forced tlast; their remainder is drained.
module axis_byte_pkt_arb #(
    parameter int NUM_SRC = 4,
    parameter int MAX_LEN = 1024,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [8*NUM_SRC-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]     s_axis_tvalid,
    input  logic [NUM_SRC-1:0]     s_axis_tlast,
    output logic [NUM_SRC-1:0]     s_axis_tready,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic [SRC_W-1:0]       m_axis_tuser,
    input  logic                   m_axis_tready,
    output logic [NUM_SRC-1:0]     trunc_err,
    input  logic                   trunc_clr
);

    localparam int LEN_W = $clog2(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DRAIN
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [SRC_W-1:0]   r_grant, w_grant_nxt;
    logic [SRC_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [LEN_W-1:0]   r_len_cnt, w_len_cnt_nxt;
    logic [NUM_SRC-1:0] r_trunc_err, w_trunc_set;

    logic [SRC_W-1:0]   w_pick;
    logic               w_pick_vld;
    logic [SRC_W-1:0]   w_grant_inc;
    logic               w_sel_vld;
    logic               w_sel_last;
    logic               w_at_max;

    // First valid source at or after the round-robin pointer, wrapping.
    always_comb begin
        logic [SRC_W-1:0] w_idx;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_idx      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_idx = SRC_W'((32'(r_rr_ptr) + i) % NUM_SRC);
            if (!w_pick_vld && s_axis_tvalid[w_idx]) begin
                w_pick     = w_idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    assign w_grant_inc  = (r_grant == SRC_W'(NUM_SRC - 1)) ? '0 : r_grant + SRC_W'(1);
    assign w_sel_vld    = s_axis_tvalid[r_grant];
    assign w_sel_last   = s_axis_tlast[r_grant];
    assign w_at_max     = (r_len_cnt == LEN_W'(MAX_LEN - 1));
    assign m_axis_tdata = s_axis_tdata[{r_grant, 3'b000} +: 8];
    assign m_axis_tuser = r_grant;
    assign trunc_err    = r_trunc_err;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_len_cnt_nxt = r_len_cnt;
        w_trunc_set   = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_grant_nxt   = w_pick;
                    w_len_cnt_nxt = '0;
                    w_state_nxt   = ST_PASS;
                end
            end
            ST_PASS: begin
                m_axis_tvalid          = w_sel_vld;
                m_axis_tlast           = w_sel_last | w_at_max;
                s_axis_tready[r_grant] = m_axis_tready;
                if (w_sel_vld && m_axis_tready) begin
                    // Source tlast takes priority: an exact MAX_LEN packet is not truncated.
                    if (w_sel_last) begin
                        w_state_nxt  = ST_IDLE;
                        w_rr_ptr_nxt = w_grant_inc;
                    end else if (w_at_max) begin
                        w_trunc_set[r_grant] = 1'b1;
                        w_state_nxt          = ST_DRAIN;
                    end else begin
                        w_len_cnt_nxt = r_len_cnt + LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                s_axis_tready[r_grant] = 1'b1;
                if (w_sel_vld && w_sel_last) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = w_grant_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_len_cnt   <= '0;
            r_trunc_err <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_len_cnt   <= w_len_cnt_nxt;
            r_trunc_err <= (r_trunc_err & ~{NUM_SRC{trunc_clr}}) | w_trunc_set;
        end
    end

endmodule

// File: tb/tb_axis_byte_pkt_arb.sv
// Self-checking bench: packet-level round-robin model predicts the output byte stream.
module tb_axis_byte_pkt_arb;

    localparam int NS = 4;
    localparam int ML = 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic [8*NS-1:0]   s_tdata;
    logic [NS-1:0]     s_tvalid, s_tlast, s_tready;
    logic [7:0]        m_tdata;
    logic              m_tvalid, m_tlast, m_tready;
    logic [1:0]        m_tuser;
    logic [NS-1:0]     trunc_err;
    logic              trunc_clr;

    axis_byte_pkt_arb #(.NUM_SRC(NS), .MAX_LEN(ML)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .trunc_err(trunc_err), .trunc_clr(trunc_clr)
    );

    always #5 aclk = ~aclk;

    typedef struct packed { logic [7:0] d; logic l; logic [1:0] u; logic tr; } beat_t;
    typedef struct packed { logic [7:0] d; logic l; logic [1:0] u; logic [31:0] cyc; } obs_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [8:0]  sq [NS][$];
    logic [8:0]  mq [NS][$];
    beat_t       exp_q[$];
    obs_t        obs[$];
    int          m_ptr    = 0;
    logic [NS-1:0] m_trunc = '0;
    logic [NS-1:0] ack_seen = '0;
    bit          bp_mode  = 0;
    bit          chk_bp   = 0;
    bit          pend_tr  = 0;
    int          pend_src = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic load(input int src, input int n, input logic [7:0] first);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = first + 8'(i);
            sq[src].push_back({(i == n - 1), b});
            mq[src].push_back({(i == n - 1), b});
        end
    endtask

    // Packet-level round robin over everything queued; cut at ML bytes, drop the rest.
    task automatic model_run();
        int src, n;
        bit found, done;
        logic [8:0] b;
        beat_t e;
        forever begin
            found = 0;
            src   = 0;
            for (int k = 0; k < NS; k++) begin
                if (!found && mq[(m_ptr + k) % NS].size() > 0) begin
                    src   = (m_ptr + k) % NS;
                    found = 1;
                end
            end
            if (!found) break;
            n    = 0;
            done = 0;
            while (!done && mq[src].size() > 0) begin
                b = mq[src].pop_front();
                n++;
                e.d = b[7:0]; e.u = 2'(src); e.l = 1'b0; e.tr = 1'b0;
                if (b[8]) begin
                    e.l = 1'b1; done = 1;
                end else if (n == ML) begin
                    e.l = 1'b1; e.tr = 1'b1; done = 1;
                    m_trunc[src] = 1'b1;
                    while (mq[src].size() > 0) begin
                        b = mq[src].pop_front();
                        if (b[8]) break;
                    end
                end
                exp_q.push_back(e);
            end
            m_ptr = (src + 1) % NS;
        end
    endtask

    function automatic bit srcs_empty();
        bit r = 1;
        for (int i = 0; i < NS; i++) if (sq[i].size() != 0) r = 0;
        return r;
    endfunction

    task automatic wait_done(input string nm);
        bit ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge aclk);
            if (exp_q.size() == 0 && srcs_empty()) ok = 1;
        end
        chk({nm, "_complete"}, 32'(ok), 32'd1);
        repeat (3) @(negedge aclk);
    endtask

    // Source drivers and output ready pattern, updated just after each rising edge.
    initial begin
        logic [8:0] h;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            for (int i = 0; i < NS; i++) begin
                if (ack_seen[i] && sq[i].size() > 0) void'(sq[i].pop_front());
                if (sq[i].size() > 0) begin
                    h = sq[i][0];
                    s_tvalid[i] = 1'b1;
                    s_tdata[8*i +: 8] = h[7:0];
                    s_tlast[i] = h[8];
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
            m_tready = bp_mode ? ~m_tready : 1'b1;
        end
    end

    // Compare process: every output transfer against the model's next beat.
    initial begin
        beat_t e;
        obs_t  o;
        forever begin
            @(negedge aclk);
            ack_seen = s_tvalid & s_tready;
            if (pend_tr) begin
                checks++;
                if (trunc_err[pend_src] !== 1'b1) begin
                    failures++;
                    $display("FAIL trunc_rise src=%0d got=%b exp=1", pend_src, trunc_err[pend_src]);
                end
                pend_tr = 0;
            end
            if (!areset) begin
                checks++;
                if ($countones(s_tready) > 1) begin
                    failures++;
                    $display("FAIL ready_onehot got=%b exp=at most one bit", s_tready);
                end
                if (chk_bp) begin
                    checks++;
                    if ((|(s_tvalid & s_tready)) && !m_tready) begin
                        failures++;
                        $display("FAIL ack_without_ready got=%b exp=0", s_tvalid & s_tready);
                    end
                end
                if (m_tvalid && m_tready) begin
                    o.d = m_tdata; o.l = m_tlast; o.u = m_tuser; o.cyc = 32'(cyc);
                    obs.push_back(o);
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL beat_unexpected got=%h/%b/%0d exp=none", m_tdata, m_tlast, m_tuser);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_tdata !== e.d || m_tlast !== e.l || m_tuser !== e.u) begin
                            failures++;
                            $display("FAIL beat got=%h/%b/%0d exp=%h/%b/%0d",
                                     m_tdata, m_tlast, m_tuser, e.d, e.l, e.u);
                        end
                        if (e.tr) begin
                            checks++;
                            if (trunc_err[e.u] !== 1'b0) begin
                                failures++;
                                $display("FAIL trunc_early got=1 exp=0");
                            end
                            pend_tr  = 1;
                            pend_src = int'(e.u);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        areset = 1'b1;
        trunc_clr = 1'b0;
        #2;
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tlast", 32'(m_tlast), 0);
        chk("rst_tuser", 32'(m_tuser), 0);
        chk("rst_sready", 32'(s_tready), 0);
        chk("rst_trunc", 32'(trunc_err), 0);
        repeat (2) @(posedge aclk);
        #2 areset = 1'b0;
        repeat (2) @(negedge aclk);

        // Single source 2, four bytes
        b = obs.size();
        load(2, 4, 8'h01);
        model_run();
        wait_done("t1");
        chk("t1_count", 32'(obs.size() - b), 4);
        if (obs.size() - b >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_data", 32'(obs[b+i].d), 32'(i + 1));
                chk("t1_last", 32'(obs[b+i].l), 32'(i == 3));
                chk("t1_user", 32'(obs[b+i].u), 2);
            end
            chk("t1_back_to_back", obs[b+3].cyc - obs[b].cyc, 3);
        end
        chk("t1_trunc", 32'(trunc_err), 0);

        // Fairness: sources 0 and 1 with three 2-byte packets each
        b = obs.size();
        for (int p = 0; p < 3; p++) begin
            load(0, 2, 8'hA0);
            load(1, 2, 8'hB0);
        end
        model_run();
        wait_done("t2");
        chk("t2_count", 32'(obs.size() - b), 12);
        if (obs.size() - b >= 12) begin
            for (int i = 0; i < 12; i++) chk("t2_user", 32'(obs[b+i].u), 32'((i / 2) % 2));
            chk("t2_b0", 32'(obs[b+2].d), 32'h0B0);
            chk("t2_gap", obs[b+2].cyc - obs[b+1].cyc, 2);
        end

        // Truncation: 10-byte packet on source 3, then an intact 3-byte packet
        b = obs.size();
        load(3, 10, 8'h01);
        load(3, 3, 8'h21);
        model_run();
        wait_done("t3");
        chk("t3_count", 32'(obs.size() - b), 11);
        if (obs.size() - b >= 11) begin
            chk("t3_forced_data", 32'(obs[b+7].d), 8'h08);
            chk("t3_forced_last", 32'(obs[b+7].l), 1);
            chk("t3_next_data", 32'(obs[b+8].d), 8'h21);
            chk("t3_next_last", 32'(obs[b+10].l), 1);
        end
        chk("t3_trunc", 32'(trunc_err), 32'b1000);
        chk("t3_trunc_model", 32'(trunc_err), 32'(m_trunc));
        @(posedge aclk); #1 trunc_clr = 1'b1;
        @(posedge aclk); #1 trunc_clr = 1'b0;
        m_trunc = '0;
        @(negedge aclk);
        chk("t3_clr", 32'(trunc_err), 0);

        // Exact MAX_LEN packet on source 1
        b = obs.size();
        load(1, 8, 8'h41);
        model_run();
        wait_done("t4");
        chk("t4_count", 32'(obs.size() - b), 8);
        if (obs.size() - b >= 8) begin
            chk("t4_last7", 32'(obs[b+7].l), 1);
            chk("t4_last6", 32'(obs[b+6].l), 0);
        end
        chk("t4_trunc", 32'(trunc_err), 0);

        // Backpressure: ready toggling during a 4-byte packet on source 2
        bp_mode = 1;
        chk_bp  = 1;
        b = obs.size();
        load(2, 4, 8'h61);
        model_run();
        wait_done("t5");
        chk_bp  = 0;
        bp_mode = 0;
        chk("t5_count", 32'(obs.size() - b), 4);
        if (obs.size() - b >= 4) begin
            for (int i = 0; i < 4; i++) chk("t5_data", 32'(obs[b+i].d), 32'(8'h61 + i));
            chk("t5_span", obs[b+3].cyc - obs[b].cyc, 6);
        end

        // Reset after 2 of 4 bytes on source 3
        b = obs.size();
        load(3, 4, 8'h81);
        model_run();
        for (int k = 0; k < 50 && obs.size() < b + 2; k++) @(negedge aclk);
        chk("t6_reached", 32'(obs.size() >= b + 2), 1);
        @(posedge aclk); #2;
        areset = 1'b1;
        for (int i = 0; i < NS; i++) begin
            sq[i].delete();
            mq[i].delete();
        end
        exp_q.delete();
        pend_tr = 0;
        m_ptr   = 0;
        m_trunc = '0;
        #1;
        chk("t6_rst_tvalid", 32'(m_tvalid), 0);
        chk("t6_rst_sready", 32'(s_tready), 0);
        chk("t6_rst_tlast", 32'(m_tlast), 0);
        chk("t6_partial", 32'(obs.size() - b), 2);
        repeat (2) @(posedge aclk);
        #2 areset = 1'b0;
        repeat (2) @(negedge aclk);
        b = obs.size();
        load(3, 1, 8'hD1);
        load(1, 2, 8'hC1);
        model_run();
        wait_done("t6");
        chk("t6_count", 32'(obs.size() - b), 3);
        if (obs.size() - b >= 3) begin
            chk("t6_first_user", 32'(obs[b].u), 1);
            chk("t6_first_data", 32'(obs[b].d), 8'hC1);
            chk("t6_third_user", 32'(obs[b+2].u), 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
